way_alloc_arbiter: RTL and testbench

WAY_ALLOC_ARBITER -- requirements
Module: way_alloc_arbiter

---
 rtl/way_alloc_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_way_alloc_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/way_alloc_arbiter.sv
// way_alloc_arbiter
// Round-robin arbiter in front of a per-set way-state table. The table holds
// one valid bit per way and an age permutation (0 = MRU, NUM_WAYS-1 = LRU).
// Each granted request (touch, allocate, invalidate) gets a registered
// response one cycle later. A flush walks the ways one per cycle, clearing
// valid bits, and then restores the age order to age[i] = i.
module way_alloc_arbiter #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_REQ  = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [2*NUM_REQ-1:0]                req_op_i,
  input  logic [NUM_REQ*$clog2(NUM_WAYS)-1:0] req_way_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                flush_i,
  output logic                                busy_o,
  output logic                                flush_done_o,
  output logic                                rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id_o,
  output logic [NUM_WAYS-1:0]                 rsp_way_o,
  output logic                                rsp_err_o
);

  localparam int WW = $clog2(NUM_WAYS);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] OP_TOUCH = 2'b01;
  localparam logic [1:0] OP_ALLOC = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  typedef logic [NUM_WAYS-1:0][WW-1:0] age_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  // Age order after reset or flush: way i has age i.
  function automatic age_t age_reset();
    age_t a;
    for (int k = 0; k < NUM_WAYS; k++) begin
      a[k] = WW'(k);
    end
    return a;
  endfunction

  // Make way w the MRU; every way younger than w ages by one.
  function automatic age_t promote(input age_t a, input logic [WW-1:0] w);
    age_t o;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (k == int'(w)) begin
        o[k] = '0;
      end else if (a[k] < a[w]) begin
        o[k] = a[k] + WW'(1);
      end else begin
        o[k] = a[k];
      end
    end
    return o;
  endfunction

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WW-1:0] w);
    logic [NUM_WAYS-1:0] o;
    o    = '0;
    o[w] = 1'b1;
    return o;
  endfunction

  // Lowest-index invalid way, or the LRU way when every way is valid.
  function automatic logic [WW-1:0] pick_victim(input logic [NUM_WAYS-1:0] v, input age_t a);
    logic [WW-1:0] inv;
    logic [WW-1:0] lru;
    inv = '0;
    lru = '0;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      inv = v[k] ? inv : WW'(k);
    end
    for (int k = 0; k < NUM_WAYS; k++) begin
      lru = (a[k] == WW'(NUM_WAYS - 1)) ? WW'(k) : lru;
    end
    return (&v) ? lru : inv;
  endfunction

  // First valid port at or after the pointer, wrapping; one-hot result.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IW-1:0] p);
    logic [NUM_REQ-1:0] g;
    logic               found;
    logic [IW-1:0]      idx;
    int                 sum;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum    = int'(p) + i;
      idx    = IW'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      g[idx] = v[idx] & ~found;
      found  = found | v[idx];
    end
    return g;
  endfunction

  function automatic logic [IW-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = idx | (IW'(i) & {IW{oh[i]}});
    end
    return idx;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_WAYS-1:0] r_valid;
  age_t                r_age;
  logic [IW-1:0]       r_ptr;
  logic [WW-1:0]       r_flush_cnt;
  logic                r_flush_done;
  logic                r_rsp_valid;
  logic [IW-1:0]       r_rsp_id;
  logic [NUM_WAYS-1:0] r_rsp_way;
  logic                r_rsp_err;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_accept;
  logic [IW-1:0]       w_gnt_idx;
  logic [1:0]          w_op;
  logic [WW-1:0]       w_way;
  logic [WW-1:0]       w_victim;
  logic                w_flush_last;
  logic [NUM_WAYS-1:0] w_valid_nxt;
  age_t                w_age_nxt;
  logic [NUM_WAYS-1:0] w_rsp_way;
  logic                w_rsp_err;

  assign w_flush_last = (r_flush_cnt == WW'(NUM_WAYS - 1));

  // Grant: blocked during reset, during a flush walk, and on the flush request cycle.
  always_comb begin
    w_grant = '0;
    if (!reset && (r_state == ST_IDLE) && !flush_i) begin
      w_grant = rr_pick(req_valid_i, r_ptr);
    end else begin
      w_grant = '0;
    end
  end

  assign w_accept  = |w_grant;
  assign w_gnt_idx = oh_to_idx(w_grant);
  assign w_op      = req_op_i[2*int'(w_gnt_idx) +: 2];
  assign w_way     = req_way_i[int'(w_gnt_idx)*WW +: WW];
  assign w_victim  = pick_victim(r_valid, r_age);

  // Next-state logic: enter FLUSH on request, leave after the last way is cleared.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (flush_i) w_state_nxt = ST_FLUSH;
        else         w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_flush_last) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_FLUSH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operation effect on the way table and the response fields, from pre-op state.
  always_comb begin
    w_valid_nxt = r_valid;
    w_age_nxt   = r_age;
    w_rsp_way   = '0;
    w_rsp_err   = 1'b0;
    case (w_op)
      OP_TOUCH: begin
        w_rsp_way = way_onehot(w_way);
        if (r_valid[w_way]) begin
          w_age_nxt = promote(r_age, w_way);
          w_rsp_err = 1'b0;
        end else begin
          w_rsp_err = 1'b1;
        end
      end
      OP_ALLOC: begin
        w_valid_nxt[w_victim] = 1'b1;
        w_age_nxt             = promote(r_age, w_victim);
        w_rsp_way             = way_onehot(w_victim);
      end
      OP_INVAL: begin
        w_valid_nxt[w_way] = 1'b0;
        w_rsp_way          = way_onehot(w_way);
      end
      default: begin
        w_rsp_err = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Way table and flush walk: the walk owns the table while FLUSH is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_age        <= age_reset();
      r_flush_cnt  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (r_state == ST_FLUSH) begin
        r_valid[r_flush_cnt] <= 1'b0;
        if (w_flush_last) begin
          r_flush_cnt  <= '0;
          r_age        <= age_reset();
          r_flush_done <= 1'b1;
        end else begin
          r_flush_cnt <= r_flush_cnt + WW'(1);
        end
      end else if (w_accept) begin
        r_valid <= w_valid_nxt;
        r_age   <= w_age_nxt;
      end
    end
  end

  // Round-robin pointer moves past the granted port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IW'(1));
    end
  end

  // Response registers: one strobe per accepted request, fields held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_way   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_id  <= w_gnt_idx;
        r_rsp_way <= w_rsp_way;
        r_rsp_err <= w_rsp_err;
      end
    end
  end

  assign req_ready_o  = w_grant;
  assign busy_o       = (r_state == ST_FLUSH);
  assign flush_done_o = r_flush_done;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_way_o    = r_rsp_way;
  assign rsp_err_o    = r_rsp_err;

endmodule

// File: tb/tb_way_alloc_arbiter.sv
// Bench for way_alloc_arbiter: a behavioural model of the way table, the
// round-robin grant and the flush walk is checked against the DUT on every
// negedge, while directed sequences pin a few hand-computed results and a
// randomized phase exercises mixed traffic and flushes.
module tb_way_alloc_arbiter;

  localparam int NW = 4;
  localparam int NR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_op;
  logic [3:0] req_way;
  logic [1:0] req_ready_o;
  logic       flush_i;
  logic       busy_o;
  logic       flush_done_o;
  logic       rsp_valid_o;
  logic [0:0] rsp_id_o;
  logic [3:0] rsp_way_o;
  logic       rsp_err_o;

  way_alloc_arbiter #(.NUM_WAYS(NW), .NUM_REQ(NR)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_way_i    (req_way),
    .req_ready_o  (req_ready_o),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .flush_done_o (flush_done_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_way_o    (rsp_way_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit         m_valid [NW];
  int         m_age   [NW];
  int         m_ptr;
  int         m_flush_left;
  bit         m_done;
  bit         m_rsp_v;
  int         m_rsp_id;
  logic [3:0] m_rsp_way;
  bit         m_rsp_err;
  logic [1:0] e_ready;
  int         e_g;
  int         e_op;
  int         e_w;
  int         e_vic;

  task automatic m_model_reset();
    for (int k = 0; k < NW; k++) begin
      m_valid[k] = 1'b0;
      m_age[k]   = k;
    end
    m_ptr        = 0;
    m_flush_left = 0;
    m_done       = 1'b0;
    m_rsp_v      = 1'b0;
    m_rsp_id     = 0;
    m_rsp_way    = 4'b0000;
    m_rsp_err    = 1'b0;
  endtask

  task automatic m_promote(input int w);
    int aw;
    aw = m_age[w];
    for (int k = 0; k < NW; k++) begin
      if (m_age[k] < aw) m_age[k] = m_age[k] + 1;
    end
    m_age[w] = 0;
  endtask

  // Compare process: check DUT against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (reset) begin
      m_model_reset();
      chk("rst_ready",     32'(req_ready_o),  32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o),  32'd0);
      chk("rst_rsp_id",    32'(rsp_id_o),     32'd0);
      chk("rst_rsp_way",   32'(rsp_way_o),    32'd0);
      chk("rst_rsp_err",   32'(rsp_err_o),    32'd0);
      chk("rst_busy",      32'(busy_o),       32'd0);
      chk("rst_done",      32'(flush_done_o), 32'd0);
    end else begin
      e_ready = 2'b00;
      e_g     = -1;
      if (m_flush_left == 0 && !flush_i) begin
        for (int i = 0; i < NR; i++) begin
          if (e_g < 0 && req_valid[(m_ptr + i) % NR]) e_g = (m_ptr + i) % NR;
        end
      end
      if (e_g >= 0) e_ready[e_g] = 1'b1;
      chk("ready",      32'(req_ready_o),  32'(e_ready));
      chk("busy",       32'(busy_o),       32'(m_flush_left > 0));
      chk("flush_done", 32'(flush_done_o), 32'(m_done));
      chk("rsp_valid",  32'(rsp_valid_o),  32'(m_rsp_v));
      if (m_rsp_v) begin
        chk("rsp_id",  32'(rsp_id_o),  32'(m_rsp_id));
        chk("rsp_way", 32'(rsp_way_o), 32'(m_rsp_way));
        chk("rsp_err", 32'(rsp_err_o), 32'(m_rsp_err));
      end
      m_done = 1'b0;
      if (m_flush_left > 0) begin
        m_valid[NW - m_flush_left] = 1'b0;
        m_flush_left--;
        if (m_flush_left == 0) begin
          for (int k = 0; k < NW; k++) m_age[k] = k;
          m_done = 1'b1;
        end
      end else if (flush_i) begin
        m_flush_left = NW;
      end
      m_rsp_v = (e_g >= 0);
      if (e_g >= 0) begin
        e_op     = int'(req_op[2*e_g +: 2]);
        e_w      = int'(req_way[2*e_g +: 2]);
        m_rsp_id = e_g;
        m_ptr    = (e_g + 1) % NR;
        case (e_op)
          1: begin
            m_rsp_way = 4'b0001 << e_w;
            if (m_valid[e_w]) begin
              m_promote(e_w);
              m_rsp_err = 1'b0;
            end else begin
              m_rsp_err = 1'b1;
            end
          end
          2: begin
            e_vic = -1;
            for (int k = 0; k < NW; k++) if (e_vic < 0 && !m_valid[k]) e_vic = k;
            if (e_vic < 0) for (int k = 0; k < NW; k++) if (m_age[k] == NW - 1) e_vic = k;
            m_valid[e_vic] = 1'b1;
            m_promote(e_vic);
            m_rsp_way = 4'b0001 << e_vic;
            m_rsp_err = 1'b0;
          end
          3: begin
            m_valid[e_w] = 1'b0;
            m_rsp_way    = 4'b0001 << e_w;
            m_rsp_err    = 1'b0;
          end
          default: begin
            m_rsp_way = 4'b0000;
            m_rsp_err = 1'b1;
          end
        endcase
      end
    end
  end

  // One request on port p, held until accepted; response checked against literals.
  task automatic do_req(input int p, input logic [1:0] op, input int way,
                        input logic [3:0] ew, input logic ee);
    bit got;
    got = 1'b0;
    req_valid[p]       = 1'b1;
    req_op[2*p +: 2]   = op;
    req_way[2*p +: 2]  = 2'(way);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready_o[p]) got = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[p] = 1'b0;
    if (!got) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("lit_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("lit_rsp_id",    32'(rsp_id_o),    32'(p));
      chk("lit_rsp_way",   32'(rsp_way_o),   32'(ew));
      chk("lit_rsp_err",   32'(rsp_err_o),   32'(ee));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill_all();
    do_req(0, 2'b10, 0, 4'b0001, 1'b0);
    do_req(0, 2'b10, 0, 4'b0010, 1'b0);
    do_req(0, 2'b10, 0, 4'b0100, 1'b0);
    do_req(0, 2'b10, 0, 4'b1000, 1'b0);
  endtask

  // Stimulus: directed sequences followed by randomized traffic.
  initial begin
    int         zeros;
    int         busy_cnt;
    int         dones;
    bit         got;
    int         n;
    logic [1:0] acc;
    logic [1:0] rr_exp;
    int         r;

    reset     = 1'b1;
    req_valid = 2'b00;
    req_op    = 4'b0000;
    req_way   = 4'b0000;
    flush_i   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Four allocates fill ways 0..3, touch way 0, then the LRU way 1 is the victim.
    fill_all();
    do_req(0, 2'b01, 0, 4'b0001, 1'b0);
    do_req(0, 2'b10, 0, 4'b0010, 1'b0);

    // Invalidate way 2 then allocate: the hole wins over age.
    do_req(1, 2'b11, 2, 4'b0100, 1'b0);
    do_req(1, 2'b10, 0, 4'b0100, 1'b0);
    // Invalidating an invalid way is legal; reserved op reports an error.
    do_req(1, 2'b11, 3, 4'b1000, 1'b0);
    do_req(1, 2'b11, 3, 4'b1000, 1'b0);
    do_req(1, 2'b00, 3, 4'b0000, 1'b1);

    // Touch of an invalid way right after reset.
    do_reset();
    do_req(0, 2'b01, 1, 4'b0010, 1'b1);
    do_req(0, 2'b10, 0, 4'b0001, 1'b0);

    // Both ports continuously requesting allocate alternate grants.
    do_reset();
    req_op    = 4'b1010;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rr_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("lit_rr_grant", 32'(req_ready_o), 32'(rr_exp));
      if (i > 0) chk("lit_rr_id", 32'(rsp_id_o), 32'((i - 1) % 2));
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("lit_rr_id", 32'(rsp_id_o), 32'd1);
    @(posedge clk); #1;

    // Flush with all ways valid and port 0 waiting.
    do_reset();
    fill_all();
    req_valid[0]  = 1'b1;
    req_op[1:0]   = 2'b10;
    flush_i       = 1'b1;
    zeros = 0; busy_cnt = 0; dones = 0; got = 1'b0; n = 0;
    while (!got && n < 12) begin
      @(negedge clk);
      busy_cnt += int'(busy_o);
      dones    += int'(flush_done_o);
      if (req_ready_o[0]) got = 1'b1;
      else                zeros++;
      @(posedge clk); #1;
      flush_i = 1'b0;
      n++;
    end
    req_valid = 2'b00;
    chk("lit_flush_grant_seen", 32'(got),      32'd1);
    chk("lit_flush_no_ready",   32'(zeros),    32'd5);
    chk("lit_flush_busy",       32'(busy_cnt), 32'd4);
    chk("lit_flush_done",       32'(dones),    32'd1);
    @(negedge clk);
    chk("lit_flush_alloc_way", 32'(rsp_way_o),   32'b0001);
    chk("lit_flush_alloc_vld", 32'(rsp_valid_o), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a flush walk aborts it without a done pulse.
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("lit_midflush_busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("lit_midflush_rst_busy", 32'(busy_o),       32'd0);
    chk("lit_midflush_rst_done", 32'(flush_done_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0; busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      dones    += int'(flush_done_o);
      busy_cnt += int'(busy_o);
      @(posedge clk); #1;
    end
    chk("lit_midflush_no_done", 32'(dones),    32'd0);
    chk("lit_midflush_no_busy", 32'(busy_cnt), 32'd0);

    // Randomized traffic: requests held until accepted, occasional flush pulses.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready_o;
      @(posedge clk); #1;
      for (int p = 0; p < NR; p++) begin
        if (!req_valid[p] || acc[p]) begin
          req_valid[p] = ($urandom % 10) < 6;
          r = int'($urandom % 8);
          if (r == 0)      req_op[2*p +: 2] = 2'b00;
          else if (r < 3)  req_op[2*p +: 2] = 2'b01;
          else if (r < 6)  req_op[2*p +: 2] = 2'b10;
          else             req_op[2*p +: 2] = 2'b11;
          req_way[2*p +: 2] = 2'($urandom % 4);
        end
      end
      flush_i = !flush_i && (($urandom % 40) == 0);
    end
    req_valid = 2'b00;
    flush_i   = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "time limit reached");
  end

endmodule
